// File: rtl/i2c_pkg.sv
// Shared types and constants for the i2c_dri arbiter.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 16;
  localparam int unsigned I2C_DATA_W = 8;

  localparam logic ACK_OK  = 1'b0;
  localparam logic ACK_ERR = 1'b1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StGap   = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending requester at or after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = 1
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_oh_o,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               valid_o
);

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    // First pass covers indices at or above the pointer, second pass wraps to the bottom.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && pending_i[i] && (i >= 32'(ptr_i))) begin
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = IdxW'(i);
        valid_o     = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!valid_o && pending_i[i]) begin
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = IdxW'(i);
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_dri among NUM_REQ requesters: captures commands, grants round-robin,
// routes completion back to the owner and aborts hung transfers with a watchdog.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter logic [15:0] TIMEOUT = 16'd2000,
  parameter logic [3:0]  GAP_CYC = 4'd4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_exec,
  input  logic [NUM_REQ-1:0]            req_rh_wl,
  input  logic [NUM_REQ-1:0]            req_bit_ctrl,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data_w,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_ack,
  output logic [I2C_DATA_W-1:0]         req_data_r,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [NUM_REQ-1:0]            req_drop,
  output logic                          timeout,
  output logic                          i2c_exec,
  output logic                          i2c_rh_wl,
  output logic                          i2c_bit_ctrl,
  output logic [I2C_ADDR_W-1:0]         i2c_addr,
  output logic [I2C_DATA_W-1:0]         i2c_data_w,
  input  logic                          i2c_done,
  input  logic                          i2c_ack,
  input  logic [I2C_DATA_W-1:0]         i2c_data_r
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d, drop_q, drop_d, load;
  logic [NUM_REQ-1:0]     rh_q, bc_q;
  logic [I2C_ADDR_W-1:0]  addr_q [NUM_REQ];
  logic [I2C_DATA_W-1:0]  dw_q   [NUM_REQ];
  logic [NUM_REQ-1:0]     gnt_oh_q, gnt_oh_d, pick_oh;
  logic [IdxW-1:0]        gnt_idx_q, gnt_idx_d, rr_q, rr_d, pick_idx;
  logic                   pick_valid;
  logic [15:0]            wdog_q, wdog_d;
  logic [3:0]             gap_q, gap_d;
  logic                   ack_q, ack_d;
  logic [I2C_DATA_W-1:0]  rdata_q, rdata_d;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .pending_i(pending_q),
    .ptr_i    (rr_q),
    .gnt_oh_o (pick_oh),
    .gnt_idx_o(pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_oh_d  = gnt_oh_q;
    gnt_idx_d = gnt_idx_q;
    rr_d      = rr_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    ack_d     = ack_q;
    rdata_d   = rdata_q;
    timeout   = 1'b0;
    req_done  = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_oh_d  = pick_oh;
          gnt_idx_d = pick_idx;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // A done arriving in the expiry cycle still counts as a normal completion.
        if (i2c_done) begin
          ack_d   = i2c_ack;
          rdata_d = i2c_data_r;
          state_d = StDone;
        end else if (wdog_q == TIMEOUT - 16'd1) begin
          ack_d   = ACK_ERR;
          rdata_d = '0;
          timeout = 1'b1;
          state_d = StDone;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StDone: begin
        req_done = gnt_oh_q;
        rr_d     = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        gap_d    = '0;
        state_d  = StGap;
      end
      StGap: begin
        if (gap_q == GAP_CYC - 4'd1) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new exec from the owner in its DONE cycle wins over the clear.
  assign load      = req_exec & (~pending_q | req_done);
  assign drop_d    = req_exec & pending_q & ~req_done;
  assign pending_d = load | (pending_q & ~req_done);

  always_comb begin
    i2c_rh_wl    = 1'b0;
    i2c_bit_ctrl = 1'b0;
    i2c_addr     = '0;
    i2c_data_w   = '0;
    if (state_q == StIssue || state_q == StWait) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt_oh_q[i]) begin
          i2c_rh_wl    = rh_q[i];
          i2c_bit_ctrl = bc_q[i];
          i2c_addr     = addr_q[i];
          i2c_data_w   = dw_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      drop_q    <= '0;
      gnt_oh_q  <= '0;
      gnt_idx_q <= '0;
      rr_q      <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
      ack_q     <= ACK_OK;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      gnt_oh_q  <= gnt_oh_d;
      gnt_idx_q <= gnt_idx_d;
      rr_q      <= rr_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        rh_q[i]   <= req_rh_wl[i];
        bc_q[i]   <= req_bit_ctrl[i];
        addr_q[i] <= req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
        dw_q[i]   <= req_data_w[I2C_DATA_W*i +: I2C_DATA_W];
      end
    end
  end

  assign i2c_exec   = (state_q == StIssue);
  assign req_busy   = pending_q;
  assign req_drop   = drop_q;
  assign req_ack    = ack_q;
  assign req_data_r = rdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural i2c_dri model (done N cycles after exec).
module tb_i2c_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam logic [15:0] TIMEOUT = 16'd2000;
  localparam logic [3:0]  GAP_CYC = 4'd4;

  logic                 clk, rst;
  logic [NUM_REQ-1:0]   req_exec, req_rh_wl, req_bit_ctrl;
  logic [16*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_data_w;
  logic [NUM_REQ-1:0]   req_done, req_busy, req_drop;
  logic                 req_ack, timeout, i2c_exec, i2c_rh_wl, i2c_bit_ctrl;
  logic [7:0]           req_data_r, i2c_data_w, i2c_data_r;
  logic [15:0]          i2c_addr;
  logic                 i2c_done, i2c_ack;

  i2c_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_exec    (req_exec),
    .req_rh_wl   (req_rh_wl),
    .req_bit_ctrl(req_bit_ctrl),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_done    (req_done),
    .req_ack     (req_ack),
    .req_data_r  (req_data_r),
    .req_busy    (req_busy),
    .req_drop    (req_drop),
    .timeout     (timeout),
    .i2c_exec    (i2c_exec),
    .i2c_rh_wl   (i2c_rh_wl),
    .i2c_bit_ctrl(i2c_bit_ctrl),
    .i2c_addr    (i2c_addr),
    .i2c_data_w  (i2c_data_w),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack),
    .i2c_data_r  (i2c_data_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Driver model settings and monitor state.
  int        mdl_lat = 0;
  int        mdl_cnt = 0;
  logic      mdl_ack = 1'b0;
  logic [7:0] mdl_data = 8'h00;
  int        cyc_n = 0;
  int        n_exec = 0, exec_cyc = 0, n_to = 0, to_cyc = 0, done_cyc = 0;
  int        n_done [NUM_REQ];
  int        n_drop [NUM_REQ];
  logic      done_ack, cap_rh, cap_bc;
  logic [7:0] done_data, cap_dw;
  logic [15:0] cap_addr;
  int        done_order [$];

  typedef struct {
    int         r;
    logic       rh;
    logic       bc;
    logic [15:0] addr;
    logic [7:0] dw;
    int         lat;
    logic       ack;
    logic [7:0] rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: model drives i2c_done at +1, monitor samples outputs at +2.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    i2c_done = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        i2c_done   = 1'b1;
        i2c_ack    = mdl_ack;
        i2c_data_r = mdl_data;
      end
    end
    #1;
    if (i2c_exec) begin
      n_exec++;
      exec_cyc = cyc_n;
      cap_rh   = i2c_rh_wl;
      cap_bc   = i2c_bit_ctrl;
      cap_addr = i2c_addr;
      cap_dw   = i2c_data_w;
      if (mdl_lat > 0) mdl_cnt = mdl_lat;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_done[i]) begin
        n_done[i]++;
        done_cyc  = cyc_n;
        done_ack  = req_ack;
        done_data = req_data_r;
        done_order.push_back(i);
      end
      if (req_drop[i]) n_drop[i]++;
    end
    if (timeout) begin
      n_to++;
      to_cyc = cyc_n;
    end
  endtask

  // Pulses exec for one cycle, then scrambles the requester's buses.
  task automatic issue(input int r, input logic rh, input logic bc, input logic [15:0] a,
                       input logic [7:0] d);
    req_exec[r] = 1'b1;
    req_rh_wl[r] = rh;
    req_bit_ctrl[r] = bc;
    req_addr[16*r +: 16] = a;
    req_data_w[8*r +: 8] = d;
    cyc();
    req_exec[r] = 1'b0;
    req_rh_wl[r] = ~rh;
    req_bit_ctrl[r] = ~bc;
    req_addr[16*r +: 16] = ~a;
    req_data_w[8*r +: 8] = ~d;
  endtask

  task automatic wait_done(input int r, input int max, input string nm);
    int start;
    bit got;
    start = n_done[r];
    got = 1'b0;
    for (int k = 0; k < max && !got; k++) begin
      cyc();
      if (n_done[r] != start) got = 1'b1;
    end
    chk({nm, "_done_arrives"}, 64'(got), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({req_done, req_ack, req_data_r, req_busy, req_drop, timeout, i2c_exec,
                i2c_rh_wl, i2c_bit_ctrl, i2c_addr, i2c_data_w});
  endfunction

  function automatic int ord(input int k);
    return (done_order.size() > k) ? done_order[k] : -1;
  endfunction

  vec_t vecs [4];
  int   c0, e0, d0, t0, dr0, dr1, nd0, nd1;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      n_done[i] = 0;
      n_drop[i] = 0;
    end
    rst = 1'b1;
    req_exec = '0; req_rh_wl = '0; req_bit_ctrl = '0; req_addr = '0; req_data_w = '0;
    i2c_done = 1'b0; i2c_ack = 1'b0; i2c_data_r = 8'h00;
    cyc();
    cyc();
    chk("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    cyc();

    // Single-requester transfers; last row ends with requester 1 so the pointer returns to 0.
    vecs[0] = '{0, 1'b1, 1'b0, 16'h00A5, 8'h00, 50, 1'b0, 8'h3C};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h1234, 8'h5A, 10, 1'b0, 8'h00};
    vecs[2] = '{0, 1'b0, 1'b1, 16'hBEEF, 8'hC3, 3,  1'b1, 8'h77};
    vecs[3] = '{1, 1'b1, 1'b0, 16'h00FF, 8'h00, 1,  1'b0, 8'h81};
    for (int v = 0; v < 4; v++) begin
      mdl_lat = vecs[v].lat; mdl_ack = vecs[v].ack; mdl_data = vecs[v].rd;
      e0 = n_exec; nd0 = n_done[0]; nd1 = n_done[1]; c0 = cyc_n;
      issue(vecs[v].r, vecs[v].rh, vecs[v].bc, vecs[v].addr, vecs[v].dw);
      chk($sformatf("v%0d_busy", v), 64'(req_busy[vecs[v].r]), 64'd1);
      wait_done(vecs[v].r, vecs[v].lat + 20, $sformatf("v%0d", v));
      chk($sformatf("v%0d_exec_latency", v), 64'(exec_cyc - c0), 64'd2);
      chk($sformatf("v%0d_exec_count", v), 64'(n_exec - e0), 64'd1);
      chk($sformatf("v%0d_bus", v), 64'({cap_rh, cap_bc, cap_addr, cap_dw}),
          64'({vecs[v].rh, vecs[v].bc, vecs[v].addr, vecs[v].dw}));
      chk($sformatf("v%0d_ack_data", v), 64'({done_ack, done_data}),
          64'({vecs[v].ack, vecs[v].rd}));
      chk($sformatf("v%0d_done_delay", v), 64'(done_cyc - exec_cyc), 64'(vecs[v].lat + 1));
      chk($sformatf("v%0d_done_counts", v), 64'({n_done[0] - nd0, n_done[1] - nd1}),
          64'({(vecs[v].r == 0) ? 1 : 0, (vecs[v].r == 1) ? 1 : 0}));
      repeat (int'(GAP_CYC) + 2) cyc();
    end
    chk("idle_bus_zero", 64'({i2c_addr, i2c_data_w, req_busy}), 64'd0);

    // Simultaneous pair: req0 first, req1 issued GAP_CYC+2 cycles after req_done[0].
    mdl_lat = 5; mdl_ack = 1'b0; mdl_data = 8'h11;
    done_order.delete();
    req_exec = 2'b11; req_addr = {16'h0B0B, 16'h0A0A};
    cyc();
    req_exec = '0;
    wait_done(0, 100, "pair0");
    d0 = done_cyc;
    wait_done(1, 100, "pair1");
    chk("pair_gap", 64'(exec_cyc - d0), 64'(int'(GAP_CYC) + 2));
    chk("pair_order", 64'({ord(0), ord(1)}), 64'({32'd0, 32'd1}));
    repeat (int'(GAP_CYC) + 2) cyc();

    // Second pair with req0 re-exec in its DONE cycle: rotation must give 0,1,0.
    done_order.delete();
    dr0 = n_drop[0];
    req_exec = 2'b11;
    cyc();
    req_exec = '0;
    wait_done(0, 100, "rot0");
    issue(0, 1'b1, 1'b0, 16'h0C0C, 8'h00);
    wait_done(1, 100, "rot1");
    wait_done(0, 100, "rot2");
    chk("rotation_order", 64'({ord(0), ord(1)}), 64'({32'd0, 32'd1}));
    chk("rotation_third", 64'(ord(2)), 64'd0);
    chk("rotation_no_drop", 64'(n_drop[0] - dr0), 64'd0);
    repeat (int'(GAP_CYC) + 2) cyc();

    // Second exec while busy is dropped and leaves the captured command alone.
    mdl_lat = 20;
    e0 = n_exec; dr1 = n_drop[1];
    issue(1, 1'b0, 1'b0, 16'h1111, 8'h22);
    repeat (3) cyc();
    issue(1, 1'b1, 1'b1, 16'h2222, 8'h33);
    cyc();
    chk("drop_pulse", 64'(n_drop[1] - dr1), 64'd1);
    wait_done(1, 60, "drop");
    repeat (int'(GAP_CYC) + 6) cyc();
    chk("drop_single_exec", 64'(n_exec - e0), 64'd1);
    chk("drop_cmd_kept", 64'({cap_rh, cap_bc, cap_addr, cap_dw}), 64'({2'b00, 16'h1111, 8'h22}));

    // Driver never answers: watchdog aborts after TIMEOUT cycles.
    mdl_lat = 0; i2c_data_r = 8'hEE; i2c_ack = 1'b0;
    t0 = n_to;
    issue(0, 1'b1, 1'b1, 16'h0777, 8'h00);
    wait_done(0, int'(TIMEOUT) + 100, "wdog");
    chk("wdog_pulse_count", 64'(n_to - t0), 64'd1);
    chk("wdog_delay", 64'(to_cyc - exec_cyc), 64'(TIMEOUT));
    chk("wdog_done_after", 64'(done_cyc - to_cyc), 64'd1);
    chk("wdog_ack_data", 64'({done_ack, done_data}), 64'({1'b1, 8'h00}));
    repeat (int'(GAP_CYC) + 2) cyc();

    // Write with re-exec in the DONE cycle: accepted, second transfer follows the gap.
    mdl_lat = 5; mdl_ack = 1'b0; mdl_data = 8'h00;
    e0 = n_exec; dr0 = n_drop[0];
    issue(0, 1'b0, 1'b0, 16'h0010, 8'h5A);
    wait_done(0, 50, "reexec_a");
    d0 = done_cyc;
    issue(0, 1'b0, 1'b1, 16'h0042, 8'h5A);
    wait_done(0, 50, "reexec_b");
    chk("reexec_no_drop", 64'(n_drop[0] - dr0), 64'd0);
    chk("reexec_exec_count", 64'(n_exec - e0), 64'd2);
    chk("reexec_second_cmd", 64'({cap_bc, cap_addr, cap_dw}), 64'({1'b1, 16'h0042, 8'h5A}));
    chk("reexec_gap", 64'(exec_cyc - d0), 64'(int'(GAP_CYC) + 2));
    repeat (int'(GAP_CYC) + 2) cyc();

    // Reset during WAIT drops everything; a fresh request afterwards runs normally.
    mdl_lat = 30;
    nd0 = n_done[0];
    issue(0, 1'b1, 1'b0, 16'h0999, 8'h00);
    repeat (10) cyc();
    rst = 1'b1;
    mdl_cnt = 0;
    cyc();
    chk("midreset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    e0 = n_exec;
    repeat (40) cyc();
    chk("midreset_no_done", 64'(n_done[0] - nd0), 64'd0);
    chk("midreset_quiet", 64'({n_exec - e0, 30'd0, req_busy}), 64'd0);
    mdl_lat = 4; mdl_ack = 1'b0; mdl_data = 8'hA7;
    issue(1, 1'b1, 1'b0, 16'h0123, 8'h00);
    wait_done(1, 50, "post_reset");
    chk("post_reset_cmd", 64'({cap_rh, cap_addr}), 64'({1'b1, 16'h0123}));
    chk("post_reset_result", 64'({done_ack, done_data}), 64'({1'b0, 8'hA7}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
